alu_op_sequencer: RTL

- Multi-cycle controller that sequences the 16-bit combinational ALU.
- Accepts one 16-bit instruction per handshake and reads source registers from the external register file.
- Drives ALU operands, opcode and Cin, then writes the result back and latches the ZCFNL flags into a PSR.
- Sits between instruction fetch and the register file / ALU datapath.

---
 rtl/alu_op_sequencer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// Four-cycle IDLE/READ/EXEC/WB sequencer driving an external combinational ALU and a sync-read register file.
// Optional: `define ALUSEQ_ILLEGAL_TRAP_EN makes an illegal opcode a sticky trap cleared only by reset_n.
module alu_op_sequencer #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [REG_AW-1:0] rf_raddr_a,
  output logic [REG_AW-1:0] rf_raddr_b,
  input  logic [DATA_W-1:0] rf_rdata_a,
  input  logic [DATA_W-1:0] rf_rdata_b,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [7:0]        alu_opcode,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_c,
  input  logic [4:0]        alu_flags,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [4:0]        psr,
  output logic              done,
  output logic              illegal
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  localparam int PSR_C = 3;

  state_t            r_state;
  state_t            w_next_state;
  logic [15:0]       r_instr;
  logic              r_legal;
  logic              r_wb_en;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [4:0]        r_flags;
  logic [4:0]        r_psr;
  logic              r_rf_we;
  logic              r_done;
  logic              r_illegal;
  logic [REG_AW-1:0] r_rf_waddr;
  logic [DATA_W-1:0] r_rf_wdata;

  logic              w_trap;
  logic              w_accept;
  logic              w_legal;
  logic              w_is_imm;
  logic              w_is_cmp;
  logic [3:0]        w_op_hi;
  logic [3:0]        w_op_ext;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_alu_b_sel;

  assign w_op_hi     = r_instr[15:12];
  assign w_op_ext    = r_instr[7:4];
  assign w_imm       = DATA_W'(r_instr[7:0]);
  assign w_alu_b_sel = w_is_imm ? w_imm : rf_rdata_b;

  // Opcode decode from the latched instruction.
  always_comb begin
    // NOTE: every always_comb output is defaulted first so no path can infer a latch.
    w_legal  = 1'b0;
    w_is_imm = 1'b0;
    w_is_cmp = 1'b0;
    case (w_op_hi)
      4'b0000: begin
        w_legal  = ((w_op_ext >= 4'd1) && (w_op_ext <= 4'd9)) ||
                   (w_op_ext == 4'd11) || (w_op_ext == 4'd15);
        w_is_cmp = (w_op_ext == 4'd11) || (w_op_ext == 4'd15);
      end
      4'b0101, 4'b0110, 4'b0111, 4'b1001: begin
        w_legal  = 1'b1;
        w_is_imm = 1'b1;
      end
      4'b1011: begin
        w_legal  = 1'b1;
        w_is_imm = 1'b1;
        w_is_cmp = 1'b1;
      end
      4'b1000: w_legal = w_op_ext inside {4'd0, 4'd1, 4'd4, 4'd8, 4'd9, 4'd10, 4'd11};
      default: ;
    endcase
  end

`ifdef ALUSEQ_ILLEGAL_TRAP_EN
  logic r_trap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                           r_trap <= 1'b0;
    else if (r_state == S_EXEC && !r_legal) r_trap <= 1'b1;
  end

  assign w_trap = r_trap;
`else
  assign w_trap = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_READ;
      S_READ:  w_next_state = S_EXEC;
      S_EXEC:  w_next_state = S_WB;
      S_WB:    w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Operands pass straight through in EXEC and are held from the captured copy afterwards.
  always_comb begin
    instr_ready = 1'b0;
    alu_a       = r_alu_a;
    alu_b       = r_alu_b;
    case (r_state)
      S_IDLE: instr_ready = reset_n & ~w_trap;
      S_EXEC: begin
        alu_a = rf_rdata_a;
        alu_b = w_alu_b_sel;
      end
      default: ;
    endcase
  end

  assign w_accept = instr_valid & instr_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_instr    <= '0;
      r_legal    <= 1'b0;
      r_wb_en    <= 1'b0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_flags    <= '0;
      r_psr      <= '0;
      r_rf_we    <= 1'b0;
      r_done     <= 1'b0;
      r_illegal  <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else begin
      r_rf_we   <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) r_instr <= instr;
        S_READ: begin
          r_legal <= w_legal;
          r_wb_en <= w_legal & ~w_is_cmp;
        end
        S_EXEC: begin
          r_alu_a    <= rf_rdata_a;
          r_alu_b    <= w_alu_b_sel;
          r_flags    <= alu_flags;
          r_rf_we    <= r_wb_en;
          r_rf_waddr <= REG_AW'(r_instr[11:8]);
          r_rf_wdata <= alu_c;
          r_done     <= 1'b1;
          r_illegal  <= ~r_legal;
        end
        S_WB: if (r_legal) r_psr <= r_flags;
        default: ;
      endcase
    end
  end

  assign rf_raddr_a = REG_AW'(r_instr[11:8]);
  assign rf_raddr_b = REG_AW'(r_instr[3:0]);
  assign alu_opcode = {w_op_hi, w_op_ext};
  assign alu_cin    = r_psr[PSR_C];
  assign rf_we      = r_rf_we;
  assign rf_waddr   = r_rf_waddr;
  assign rf_wdata   = r_rf_wdata;
  assign psr        = r_psr;
  assign done       = r_done;
  assign illegal    = r_illegal | w_trap;

endmodule
